key_event_ctrl: RTL and testbench

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

---
 rtl/key_event_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_key_event_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_ctrl.sv
//==============================================================================
// Module      : key_event_ctrl
// Description : Debounced multi-key scanner. Each active-low key is
//               synchronised, sampled on a shared 10 ms tick by a per-key
//               FSM, and classified as a short or long press. Each event is
//               held in a per-key pending slot, then moved round-robin into a
//               4-deep first-word-fall-through FIFO. A sticky flag records
//               lost events.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module key_event_ctrl #(
  parameter int CLK_FREQ   = 100000000,
  parameter int NUM_KEYS   = 4,
  parameter int LONG_TICKS = 100
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NUM_KEYS-1:0] key_i,
  input  logic                evt_ready_i,
  input  logic                ovf_clr_i,
  output logic                evt_valid_o,
  output logic [2:0]          evt_key_o,
  output logic                evt_long_o,
  output logic [NUM_KEYS-1:0] key_state_o,
  output logic                ovf_o
);

  localparam int TICK_DIV = (CLK_FREQ / 100 < 1) ? 1 : CLK_FREQ / 100;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W   = $clog2(LONG_TICKS + 1);
  localparam int PTR_W    = $clog2(NUM_KEYS);

  localparam logic [1:0] S0_IDLE  = 2'd0;
  localparam logic [1:0] S1_PRESS = 2'd1;
  localparam logic [1:0] S2_DOWN  = 2'd2;
  localparam logic [1:0] S3_REL   = 2'd3;

  // ---------------------------------------------------------------------------
  // Input synchroniser (idles released) and shared scan tick
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] sync_meta;
  logic [NUM_KEYS-1:0] sync_key;
  logic [NUM_KEYS-1:0] pressed;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;

  // Two-flop synchroniser; reset value 1 means "released".
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_meta <= '1;
      sync_key  <= '1;
    end else begin
      sync_meta <= key_i;
      sync_key  <= sync_meta;
    end
  end

  assign pressed = ~sync_key;
  assign tick    = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Free-running tick divider, wraps at the terminal count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-key debounce / classification FSM
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] raise;
  logic [NUM_KEYS-1:0] raise_long;

  generate
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      logic [1:0]        state;
      logic [1:0]        state_nxt;
      logic [HOLD_W-1:0] hold_cnt;
      logic [HOLD_W-1:0] hold_nxt;
      logic              long_done;
      logic              done_nxt;
      logic              evt;
      logic              evt_long;
      logic              down;

      // State, hold counter and long_done registers.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          state     <= S0_IDLE;
          hold_cnt  <= '0;
          long_done <= 1'b0;
        end else begin
          state     <= state_nxt;
          hold_cnt  <= hold_nxt;
          long_done <= done_nxt;
        end
      end

      // Next-state logic; only advances on the scan tick.
      always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        done_nxt  = long_done;
        if (tick) begin
          case (state)
            S0_IDLE: begin
              if (pressed[k]) state_nxt = S1_PRESS;
            end
            S1_PRESS: begin
              if (pressed[k]) begin
                state_nxt = S2_DOWN;
                hold_nxt  = '0;
              end else begin
                state_nxt = S0_IDLE;
              end
            end
            S2_DOWN: begin
              if (!pressed[k]) begin
                state_nxt = S3_REL;
              end else if (hold_cnt != HOLD_W'(LONG_TICKS)) begin
                hold_nxt = hold_cnt + 1'b1;
                if (hold_cnt == HOLD_W'(LONG_TICKS - 1)) done_nxt = 1'b1;
              end
            end
            default: begin
              if (!pressed[k]) begin
                state_nxt = S0_IDLE;
                done_nxt  = 1'b0;
              end else begin
                state_nxt = S2_DOWN;
              end
            end
          endcase
        end
      end

      // Event and debounced-level outputs decoded from the current state.
      always_comb begin
        evt      = 1'b0;
        evt_long = 1'b0;
        down     = (state == S2_DOWN) || (state == S3_REL);
        if (tick && !long_done) begin
          if (state == S2_DOWN && pressed[k] &&
              hold_cnt == HOLD_W'(LONG_TICKS - 1)) begin
            evt      = 1'b1;
            evt_long = 1'b1;
          end else if (state == S3_REL && !pressed[k]) begin
            evt = 1'b1;
          end
        end
      end

      assign raise[k]       = evt;
      assign raise_long[k]  = evt_long;
      assign key_state_o[k] = down;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pending slots, round-robin arbiter, event FIFO
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] pend_valid;
  logic [NUM_KEYS-1:0] pend_long;
  logic [NUM_KEYS-1:0] take;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_found;
  logic                push;
  logic                pop;
  logic                lost;
  logic [3:0]          fifo_mem [0:3];
  logic [1:0]          wr_ptr;
  logic [1:0]          rd_ptr;
  logic [2:0]          fifo_cnt;

  // Lowest pending index at or after rr_ptr, wrapping around.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_KEYS;
      if (!grant_found && pend_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign pop  = (fifo_cnt != 3'd0) && evt_ready_i;
  assign push = grant_found && ((fifo_cnt != 3'd4) || pop);
  assign take = push ? (NUM_KEYS'(1) << grant_idx) : '0;
  // A slot is lost only if it is still occupied after this cycle's grant.
  assign lost = |(raise & pend_valid & ~take);

  // Pending slots: a new event overwrites, a grant clears.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_valid <= '0;
      pend_long  <= '0;
    end else begin
      pend_valid <= (pend_valid & ~take) | raise;
      pend_long  <= (pend_long & ~raise) | (raise_long & raise);
    end
  end

  // Round-robin pointer moves past each granted key.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (grant_idx == PTR_W'(NUM_KEYS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // FIFO storage and pointers; entry is {key index, long flag}.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {3'(grant_idx), pend_long[grant_idx]};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign evt_valid_o               = (fifo_cnt != 3'd0);
  assign {evt_key_o, evt_long_o}   = evt_valid_o ? fifo_mem[rd_ptr] : 4'b0;

  // Sticky overflow flag; a new loss wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_o <= 1'b0;
    end else if (lost) begin
      ovf_o <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_o <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
//==============================================================================
// Module      : tb_key_event_ctrl
// Description : Self-checking bench for key_event_ctrl with a cycle-level
//               behavioural model, directed scenarios and random key traffic.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_key_event_ctrl;

  localparam int CLK_FREQ = 1000;
  localparam int NK       = 4;
  localparam int LONG     = 8;
  localparam int DIV      = CLK_FREQ / 100;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [NK-1:0] key     = '1;
  logic          ready   = 1'b1;
  logic          ovf_clr = 1'b0;
  logic          evt_valid;
  logic [2:0]    evt_key;
  logic          evt_long;
  logic [NK-1:0] key_state;
  logic          ovf;

  key_event_ctrl #(
    .CLK_FREQ  (CLK_FREQ),
    .NUM_KEYS  (NK),
    .LONG_TICKS(LONG)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .key_i      (key),
    .evt_ready_i(ready),
    .ovf_clr_i  (ovf_clr),
    .evt_valid_o(evt_valid),
    .evt_key_o  (evt_key),
    .evt_long_o (evt_long),
    .key_state_o(key_state),
    .ovf_o      (ovf)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: debounced level flips after two agreeing tick samples.
  // ---------------------------------------------------------------------------
  logic [NK-1:0] m_s1, m_s2;
  int  m_cnt;
  bit  m_down [NK];
  int  m_opp  [NK];
  int  m_hold [NK];
  bit  m_ldone[NK];
  bit  m_pv   [NK];
  bit  m_pl   [NK];
  int  m_rr;
  bit  m_ovf;
  int  m_fifo[$];

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_cnt = 0; m_rr = 0; m_ovf = 0;
    m_fifo.delete();
    for (int k = 0; k < NK; k++) begin
      m_down[k] = 0; m_opp[k] = 0; m_hold[k] = 0; m_ldone[k] = 0;
      m_pv[k] = 0; m_pl[k] = 0;
    end
  endtask

  task automatic model_step();
    bit pressed[NK];
    bit rs[NK];
    bit rl[NK];
    bit tick, pop, lost;
    int g;
    for (int k = 0; k < NK; k++) begin
      pressed[k] = !m_s2[k];
      rs[k] = 0; rl[k] = 0;
    end
    tick  = (m_cnt == DIV - 1);
    m_s2  = m_s1;
    m_s1  = key;
    m_cnt = tick ? 0 : m_cnt + 1;
    if (tick) begin
      for (int k = 0; k < NK; k++) begin
        if (!m_down[k]) begin
          if (pressed[k]) begin
            m_opp[k]++;
            if (m_opp[k] == 2) begin m_down[k] = 1; m_opp[k] = 0; m_hold[k] = 0; end
          end else m_opp[k] = 0;
        end else if (!pressed[k]) begin
          m_opp[k]++;
          if (m_opp[k] == 2) begin
            m_down[k] = 0; m_opp[k] = 0;
            if (!m_ldone[k]) rs[k] = 1;
            m_ldone[k] = 0;
          end
        end else if (m_opp[k] == 1) begin
          m_opp[k] = 0;
        end else if (m_hold[k] < LONG) begin
          m_hold[k]++;
          if (m_hold[k] == LONG && !m_ldone[k]) begin rs[k] = 1; rl[k] = 1; m_ldone[k] = 1; end
        end
      end
    end
    pop = (m_fifo.size() > 0) && ready;
    g = -1;
    for (int i = 0; i < NK; i++)
      if (g < 0 && m_pv[(m_rr + i) % NK]) g = (m_rr + i) % NK;
    if (m_fifo.size() == 4 && !pop) g = -1;
    if (pop) void'(m_fifo.pop_front());
    if (g >= 0) begin
      m_fifo.push_back(g * 2 + int'(m_pl[g]));
      m_pv[g] = 0;
      m_rr = (g + 1) % NK;
    end
    lost = 0;
    for (int k = 0; k < NK; k++) begin
      if (rs[k]) begin
        if (m_pv[k]) lost = 1;
        m_pv[k] = 1;
        m_pl[k] = rl[k];
      end
    end
    if (lost) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // ---------------------------------------------------------------------------
  // Per-cycle comparison and observed-pop log
  // ---------------------------------------------------------------------------
  int            cyc = 0;
  bit            prev_v = 0;
  int            prev_h = 0;
  bit            last_ready = 0;
  bit            last_rst = 0;
  int            obs[$];
  int            obs_cyc[$];
  logic [NK-1:0] seen_state = '0;

  always @(posedge clk) begin
    last_ready <= ready;
    last_rst   <= rst_n;
  end

  task automatic step();
    logic [NK-1:0] m_state;
    int            e_key, e_long;
    @(negedge clk);
    cyc++;
    if (prev_v && last_ready && last_rst) begin
      obs.push_back(prev_h);
      obs_cyc.push_back(cyc);
    end
    prev_v     = evt_valid;
    prev_h     = int'(evt_key) * 2 + int'(evt_long);
    seen_state = seen_state | key_state;
    for (int k = 0; k < NK; k++) m_state[k] = m_down[k];
    e_key  = (m_fifo.size() > 0) ? m_fifo[0] / 2 : 0;
    e_long = (m_fifo.size() > 0) ? m_fifo[0] % 2 : 0;
    check("evt_valid", evt_valid, (m_fifo.size() > 0) ? 1 : 0);
    check("evt_key", evt_key, e_key);
    check("evt_long", evt_long, e_long);
    check("key_state", key_state, m_state);
    check("ovf", ovf, m_ovf);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic new_scenario();
    obs.delete();
    obs_cyc.delete();
    seen_state = '0;
  endtask

  int dur[NK];
  int seq[6] = '{0, 1, 2, 3, 0, 0};
  int exp_drain[5] = '{0, 2, 4, 6, 0};

  initial begin
    // Reset state
    wait_cycles(3);
    check("rst_valid", evt_valid, 0);
    check("rst_key", evt_key, 0);
    check("rst_long", evt_long, 0);
    check("rst_state", key_state, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    wait_cycles(5);

    // Short press on key 0
    new_scenario();
    key[0] = 1'b0; wait_cycles(50);
    key[0] = 1'b1; wait_cycles(60);
    check("short_cnt", obs.size(), 1);
    if (obs.size() > 0) check("short_evt", obs[0], 0);
    check("short_level", seen_state[0], 1);

    // One-tick glitch on key 1
    new_scenario();
    key[1] = 1'b0; wait_cycles(10);
    key[1] = 1'b1; wait_cycles(40);
    check("glitch_cnt", obs.size(), 0);
    check("glitch_level", seen_state[1], 0);

    // Long press on key 2
    new_scenario();
    key[2] = 1'b0; wait_cycles(120);
    check("long_cnt_held", obs.size(), 1);
    key[2] = 1'b1; wait_cycles(60);
    check("long_cnt", obs.size(), 1);
    if (obs.size() > 0) check("long_evt", obs[0], 5);

    // Simultaneous release on keys 1 and 3 from rr_ptr = 0
    rst_n = 1'b0; wait_cycles(2);
    rst_n = 1'b1; wait_cycles(3);
    new_scenario();
    key[1] = 1'b0; key[3] = 1'b0; wait_cycles(40);
    key[1] = 1'b1; key[3] = 1'b1; wait_cycles(60);
    check("rr_cnt", obs.size(), 2);
    if (obs.size() == 2) begin
      check("rr_first", obs[0], 2);
      check("rr_second", obs[1], 6);
      check("rr_gap", obs_cyc[1] - obs_cyc[0], 1);
    end

    // FIFO full and overflow with the consumer stalled
    new_scenario();
    ready = 1'b0;
    foreach (seq[i]) begin
      key[seq[i]] = 1'b0; wait_cycles(30);
      key[seq[i]] = 1'b1; wait_cycles(40);
    end
    check("full_valid", evt_valid, 1);
    check("full_ovf", ovf, 1);
    ready = 1'b1; wait_cycles(20);
    check("drain_cnt", obs.size(), 5);
    foreach (exp_drain[i])
      if (i < obs.size()) check("drain_evt", obs[i], exp_drain[i]);
    check("ovf_hold", ovf, 1);
    ovf_clr = 1'b1; step();
    ovf_clr = 1'b0;
    check("ovf_clr", ovf, 0);

    // Reset while key 0 is held down
    new_scenario();
    key[0] = 1'b0; wait_cycles(40);
    check("pre_rst_level", key_state[0], 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", evt_valid, 0);
    check("midrst_key", evt_key, 0);
    check("midrst_long", evt_long, 0);
    check("midrst_state", key_state, 0);
    check("midrst_ovf", ovf, 0);
    wait_cycles(3);
    rst_n = 1'b1;
    new_scenario();
    wait_cycles(50);
    check("post_rst_cnt", obs.size(), 0);
    key[0] = 1'b1; wait_cycles(60);

    // Random traffic against the model
    for (int k = 0; k < NK; k++) dur[k] = $urandom_range(1, 140);
    for (int c = 0; c < 6000; c++) begin
      for (int k = 0; k < NK; k++) begin
        dur[k]--;
        if (dur[k] <= 0) begin
          key[k] = ~key[k];
          dur[k] = $urandom_range(1, 140);
        end
      end
      ready   = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 49) == 0);
      rst_n   = ($urandom_range(0, 2999) != 0);
      step();
    end
    rst_n = 1'b1;
    wait_cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
